// File: rtl/vs_result_buffer_pkg.sv
// Shared types for the result buffer.
// Holds the buffer geometry, the pickup request type, the pickup FSM states
// and the per-entry state bits.
package vs_result_buffer_pkg;

    localparam int unsigned RESULT_BUFFER_SIZE    = 8;
    localparam int unsigned RESULT_BUFFER_ID_SIZE = $clog2(RESULT_BUFFER_SIZE);
    localparam int unsigned RESULT_BUFFER_DATA_W  = 32;

    typedef logic [RESULT_BUFFER_DATA_W-1:0] ResultBufferEntryType;

    typedef struct packed {
        logic                             Enable;
        logic [RESULT_BUFFER_ID_SIZE-1:0] RBIdx;
    } RBPickupType;

    typedef enum logic [0:0] {
        RB_PICK_IDLE,
        RB_PICK_WAIT
    } RBPickStateType;

    typedef struct packed {
        logic alloc;
        logic valid;
    } RBEntryStateType;

endpackage

// File: rtl/vs_rb_free_finder.sv
// Lowest-set-bit priority encoder.
// Ports:
//   vec_i   - candidate vector (bit set = entry available)
//   found_o - at least one bit of vec_i is set
//   idx_o   - index of the lowest set bit (0 when nothing is found)
module vs_rb_free_finder
    import vs_result_buffer_pkg::*;
#(
    parameter int unsigned Width = RESULT_BUFFER_SIZE,
    parameter int unsigned IdxW  = $clog2(Width)
) (
    input  logic [Width-1:0] vec_i,
    output logic             found_o,
    output logic [IdxW-1:0]  idx_o
);

    // Scan downwards so the lowest set bit is the last one to assign.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                idx_o   = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/vs_result_buffer.sv
// Result buffer: holds results of skipped computations until decode picks
// them up.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   flush_i                 - synchronous clear of all entries and the pickup FSM
//   alloc_req_i/gnt_o/idx_o - entry allocation from the skip table
//   wr_en_i/idx_i/data_i    - execute write-back
//   free_en_i/free_idx_i    - explicit entry release
//   pick_i                  - pickup request {Enable, RBIdx}
//   pick_busy_o             - pickup is waiting for its result
//   pick_valid_o/data_o     - one-cycle pickup response
//   count_o, full_o         - allocated entry count, buffer full
//   err_o                   - sticky protocol error
module vs_result_buffer
    import vs_result_buffer_pkg::*;
#(
    parameter int unsigned RB_SIZE = RESULT_BUFFER_SIZE,
    parameter int unsigned DATA_W  = RESULT_BUFFER_DATA_W,
    parameter int unsigned IDX_W   = RESULT_BUFFER_ID_SIZE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [IDX_W-1:0]  alloc_idx_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              free_en_i,
    input  logic [IDX_W-1:0]  free_idx_i,
    input  RBPickupType       pick_i,
    output logic              pick_busy_o,
    output logic              pick_valid_o,
    output logic [DATA_W-1:0] pick_data_o,
    output logic [IDX_W:0]    count_o,
    output logic              full_o,
    output logic              err_o
);

    localparam int unsigned CountW = IDX_W + 1;

    RBEntryStateType   st_q   [RB_SIZE];
    RBEntryStateType   st_d   [RB_SIZE];
    logic [DATA_W-1:0] data_q [RB_SIZE];
    logic [CountW-1:0] count_q, count_d;
    logic              full_q;

    RBPickStateType    state_q;
    logic [IDX_W-1:0]  pend_idx_q;
    logic              pick_busy_q, pick_valid_q, err_q;
    logic [DATA_W-1:0] pick_data_q;

    logic [RB_SIZE-1:0] free_vec;
    logic               free_found;
    logic               wr_ok, wr_err, free_ok, free_err;
    logic [IDX_W-1:0]   pidx;

    assign pidx = IDX_W'(pick_i.RBIdx);

    always_comb begin
        free_vec = '0;
        for (int i = 0; i < int'(RB_SIZE); i++) begin
            free_vec[i] = ~st_q[i].alloc;
        end
    end

    vs_rb_free_finder #(
        .Width(RB_SIZE),
        .IdxW (IDX_W)
    ) u_free_finder (
        .vec_i  (free_vec),
        .found_o(free_found),
        .idx_o  (alloc_idx_o)
    );

    assign alloc_gnt_o = alloc_req_i && !full_q && free_found;

    // A free to the same index as a write discards the write.
    assign wr_ok    = wr_en_i && st_q[wr_idx_i].alloc &&
                      !(free_en_i && (free_idx_i == wr_idx_i));
    assign wr_err   = wr_en_i && !st_q[wr_idx_i].alloc;
    assign free_ok  = free_en_i && st_q[free_idx_i].alloc;
    assign free_err = free_en_i && !st_q[free_idx_i].alloc;

    // Grant always targets an unallocated entry, so it never collides with
    // an accepted write or free.
    always_comb begin
        st_d = st_q;
        if (wr_ok) begin
            st_d[wr_idx_i].valid = 1'b1;
        end
        if (free_ok) begin
            st_d[free_idx_i] = '0;
        end
        if (alloc_gnt_o) begin
            st_d[alloc_idx_o].alloc = 1'b1;
            st_d[alloc_idx_o].valid = 1'b0;
        end
        count_d = count_q + CountW'(alloc_gnt_o) - CountW'(free_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(RB_SIZE); i++) begin
                st_q[i]   <= '0;
                data_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < int'(RB_SIZE); i++) begin
                st_q[i]   <= '0;
                data_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            if (wr_ok) begin
                data_q[wr_idx_i] <= wr_data_i;
            end
            count_q <= count_d;
            full_q  <= (count_d == CountW'(RB_SIZE));
        end
    end

    // Pickup FSM with registered outputs; also owns the sticky error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RB_PICK_IDLE;
            pend_idx_q   <= '0;
            pick_busy_q  <= 1'b0;
            pick_valid_q <= 1'b0;
            pick_data_q  <= '0;
            err_q        <= 1'b0;
        end else if (flush_i) begin
            state_q      <= RB_PICK_IDLE;
            pend_idx_q   <= '0;
            pick_busy_q  <= 1'b0;
            pick_valid_q <= 1'b0;
            pick_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            pick_valid_q <= 1'b0;
            err_q        <= err_q | wr_err | free_err;
            unique case (state_q)
                RB_PICK_IDLE: begin
                    if (pick_i.Enable) begin
                        if (!st_q[pidx].alloc) begin
                            err_q <= 1'b1;
                        end else if (st_q[pidx].valid) begin
                            pick_valid_q <= 1'b1;
                            pick_data_q  <= data_q[pidx];
                        end else if (wr_ok && (wr_idx_i == pidx)) begin
                            pick_valid_q <= 1'b1;
                            pick_data_q  <= wr_data_i;
                        end else if (free_en_i && (free_idx_i == pidx)) begin
                            // Entry vanishes before its result arrives.
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= RB_PICK_WAIT;
                            pend_idx_q  <= pidx;
                            pick_busy_q <= 1'b1;
                        end
                    end
                end
                RB_PICK_WAIT: begin
                    if (free_en_i && (free_idx_i == pend_idx_q)) begin
                        err_q       <= 1'b1;
                        state_q     <= RB_PICK_IDLE;
                        pick_busy_q <= 1'b0;
                    end else if (wr_en_i && (wr_idx_i == pend_idx_q)) begin
                        pick_valid_q <= 1'b1;
                        pick_data_q  <= wr_data_i;
                        state_q      <= RB_PICK_IDLE;
                        pick_busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= RB_PICK_IDLE;
                    pick_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign pick_busy_o  = pick_busy_q;
    assign pick_valid_o = pick_valid_q;
    assign pick_data_o  = pick_data_q;
    assign count_o      = count_q;
    assign full_o       = full_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_vs_result_buffer.sv
module tb_vs_result_buffer;
    import vs_result_buffer_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst, flush, alloc_req, wr_en, free_en;
    logic [2:0]  wr_idx, free_idx;
    logic [31:0] wr_data;
    RBPickupType pick;
    logic        alloc_gnt;
    logic [2:0]  alloc_idx;
    logic        pick_busy, pick_valid, full, err;
    logic [31:0] pick_data;
    logic [3:0]  count;

    always #5 clk = ~clk;

    vs_result_buffer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .alloc_req_i (alloc_req),
        .alloc_gnt_o (alloc_gnt),
        .alloc_idx_o (alloc_idx),
        .wr_en_i     (wr_en),
        .wr_idx_i    (wr_idx),
        .wr_data_i   (wr_data),
        .free_en_i   (free_en),
        .free_idx_i  (free_idx),
        .pick_i      (pick),
        .pick_busy_o (pick_busy),
        .pick_valid_o(pick_valid),
        .pick_data_o (pick_data),
        .count_o     (count),
        .full_o      (full),
        .err_o       (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: entry table plus the index of an outstanding pickup.
    bit          m_alloc [N];
    bit          m_valid [N];
    logic [31:0] m_data  [N];
    bit          m_err;
    int          m_pend;
    bit          m_pv;
    logic [31:0] m_pd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_alloc[i]);
        return c;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (!m_alloc[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_alloc[i] = 0;
            m_valid[i] = 0;
            m_data[i]  = '0;
        end
        m_err  = 0;
        m_pend = -1;
        m_pv   = 0;
        m_pd   = '0;
    endtask

    task automatic model_edge(input bit gnt, input int gidx);
        int p;
        bit fr_same;
        if (flush) begin
            model_reset();
            return;
        end
        m_pv = 0;
        p = int'(pick.RBIdx);
        if (m_pend >= 0) begin
            if (free_en && int'(free_idx) == m_pend) begin
                m_err  = 1;
                m_pend = -1;
            end else if (wr_en && int'(wr_idx) == m_pend) begin
                m_pv   = 1;
                m_pd   = wr_data;
                m_pend = -1;
            end
        end else if (pick.Enable) begin
            fr_same = free_en && int'(free_idx) == p;
            if (!m_alloc[p]) m_err = 1;
            else if (m_valid[p]) begin
                m_pv = 1;
                m_pd = m_data[p];
            end else if (wr_en && int'(wr_idx) == p && !fr_same) begin
                m_pv = 1;
                m_pd = wr_data;
            end else if (fr_same) m_err = 1;
            else m_pend = p;
        end
        if (wr_en) begin
            if (!m_alloc[wr_idx]) m_err = 1;
            else if (!(free_en && free_idx == wr_idx)) begin
                m_valid[wr_idx] = 1;
                m_data[wr_idx]  = wr_data;
            end
        end
        if (free_en) begin
            if (!m_alloc[free_idx]) m_err = 1;
            else begin
                m_alloc[free_idx] = 0;
                m_valid[free_idx] = 0;
            end
        end
        if (gnt) begin
            m_alloc[gidx] = 1;
            m_valid[gidx] = 0;
        end
    endtask

    task automatic check_regs();
        check_eq("pick_valid", pick_valid, m_pv);
        check_eq("pick_busy", pick_busy, m_pend >= 0);
        if (m_pv) check_eq("pick_data", pick_data, m_pd);
        check_eq("count", count, m_count());
        check_eq("full", full, m_count() == N);
        check_eq("err", err, m_err);
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        bit gnt;
        int gidx;
        #1;
        gnt  = alloc_req && (m_count() < N);
        gidx = lowest_free();
        check_eq("alloc_gnt", alloc_gnt, gnt);
        if (gnt) check_eq("alloc_idx", alloc_idx, gidx);
        @(posedge clk);
        model_edge(gnt, gidx);
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle();
        flush       = 0;
        alloc_req   = 0;
        wr_en       = 0;
        wr_idx      = '0;
        wr_data     = '0;
        free_en     = 0;
        free_idx    = '0;
        pick.Enable = 0;
        pick.RBIdx  = '0;
    endtask

    task automatic do_flush();
        idle();
        flush = 1;
        step();
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_count", count, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_pick_valid", pick_valid, 0);
        check_eq("rst_pick_busy", pick_busy, 0);
        check_eq("rst_pick_data", pick_data, 0);
        rst = 0;

        // Fill all entries, ninth request must be refused.
        for (int i = 0; i < 9; i++) begin
            alloc_req = 1;
            #1;
            check_eq("fill_gnt", alloc_gnt, i < 8);
            if (i < 8) check_eq("fill_idx", alloc_idx, i);
            step();
        end
        idle();
        check_eq("fill_count", count, 8);
        check_eq("fill_full", full, 1);

        // Write then pick a valid entry.
        do_flush();
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1;
            step();
        end
        idle();
        wr_en = 1; wr_idx = 3; wr_data = 32'hDEADBEEF;
        step();
        idle();
        pick.Enable = 1; pick.RBIdx = 3;
        step();
        check_eq("pick3_valid", pick_valid, 1);
        check_eq("pick3_data", pick_data, 32'hDEADBEEF);
        check_eq("pick3_busy", pick_busy, 0);

        // Pick before the result exists, then satisfy it from the WAIT state.
        pick.RBIdx = 0;
        step();
        check_eq("wait_busy", pick_busy, 1);
        check_eq("wait_valid", pick_valid, 0);
        for (int i = 0; i < 4; i++) step();
        check_eq("wait_busy_held", pick_busy, 1);
        wr_en = 1; wr_idx = 0; wr_data = 32'h12345678;
        step();
        idle();
        check_eq("wait_done_valid", pick_valid, 1);
        check_eq("wait_done_data", pick_data, 32'h12345678);
        check_eq("wait_done_busy", pick_busy, 0);

        // Same-cycle write is forwarded without waiting.
        pick.Enable = 1; pick.RBIdx = 2;
        wr_en = 1; wr_idx = 2; wr_data = 32'hA5A5A5A5;
        step();
        idle();
        check_eq("fwd_valid", pick_valid, 1);
        check_eq("fwd_data", pick_data, 32'hA5A5A5A5);
        check_eq("fwd_busy", pick_busy, 0);

        // Protocol errors are sticky until flush.
        do_flush();
        wr_en = 1; wr_idx = 5; wr_data = 32'h1;
        step();
        idle();
        check_eq("err_wr", err, 1);
        step();
        check_eq("err_sticky", err, 1);
        do_flush();
        check_eq("err_flushed", err, 0);
        pick.Enable = 1; pick.RBIdx = 6;
        step();
        idle();
        check_eq("err_pick", err, 1);
        check_eq("err_pick_valid", pick_valid, 0);
        do_flush();
        check_eq("flush_err", err, 0);
        check_eq("flush_count", count, 0);

        // Free and allocate together on a full buffer.
        for (int i = 0; i < 8; i++) begin
            alloc_req = 1;
            step();
        end
        free_en = 1; free_idx = 4;
        #1;
        check_eq("full_free_gnt", alloc_gnt, 0);
        step();
        idle();
        check_eq("full_free_count", count, 7);
        alloc_req = 1;
        #1;
        check_eq("refill_gnt", alloc_gnt, 1);
        check_eq("refill_idx", alloc_idx, 4);
        step();
        idle();

        // Asynchronous reset in the middle of a WAIT.
        pick.Enable = 1; pick.RBIdx = 4;
        step();
        check_eq("rst_wait_busy_pre", pick_busy, 1);
        rst = 1;
        #1;
        check_eq("rst_wait_busy", pick_busy, 0);
        check_eq("rst_wait_count", count, 0);
        idle();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            idle();
            flush       = ($urandom_range(0, 99) < 2);
            alloc_req   = ($urandom_range(0, 99) < 50);
            wr_en       = ($urandom_range(0, 99) < 40);
            wr_idx      = 3'($urandom_range(0, 7));
            wr_data     = $urandom;
            free_en     = ($urandom_range(0, 99) < 20);
            free_idx    = 3'($urandom_range(0, 7));
            pick.Enable = ($urandom_range(0, 99) < 40);
            pick.RBIdx  = 3'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
